// File: rtl/pipeline_hazard_ctl.sv
// rtl/pipeline_hazard_ctl.sv - load-use stall, redirect flush and debug halt control for a 5-stage pipeline
//
// Purpose:
//   Detects RAW hazards between the ID/EX producer and the IF/ID consumer,
//   stalls or flushes the front of the pipeline, and freezes it on a debug
//   halt request with single-step support. Counts stall and flush events.
//
// Ports:
//   clk, reset          - clock; synchronous active-high reset
//   ifid_rs_i/rt_i      - source register fields of the IF/ID instruction
//   ifid_uses_rt_i      - IF/ID instruction actually reads rt
//   idex_reg_write_i    - ID/EX instruction writes a register
//   idex_write_reg_i    - ID/EX destination register
//   redirect_i          - EX-stage taken branch or jump
//   halt_req_i, step_i  - debug halt level and single-step pulse
//   pc_enable_o .. idex_flush_o - combinational pipeline register controls
//   halted_o            - registered, high while in HALT
//   stall_count_o, flush_count_o - saturating event counters

module pipeline_hazard_ctl #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [4:0]           ifid_rs_i,
  input  logic [4:0]           ifid_rt_i,
  input  logic                 ifid_uses_rt_i,
  input  logic                 idex_reg_write_i,
  input  logic [4:0]           idex_write_reg_i,
  input  logic                 redirect_i,
  input  logic                 halt_req_i,
  input  logic                 step_i,
  output logic                 pc_enable_o,
  output logic                 ifid_enable_o,
  output logic                 ifid_flush_o,
  output logic                 idex_enable_o,
  output logic                 idex_flush_o,
  output logic                 halted_o,
  output logic [CNT_WIDTH-1:0] stall_count_o,
  output logic [CNT_WIDTH-1:0] flush_count_o
);

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    HALT = 2'd1,
    STEP = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  state_t state;
  logic   hz;
  logic   active;
  logic   stall_evt;
  logic   flush_evt;

  // Register 0 is hardwired to zero, so writes to it never create a hazard.
  assign hz = idex_reg_write_i && (idex_write_reg_i != 5'd0) &&
              ((idex_write_reg_i == ifid_rs_i) ||
               (ifid_uses_rt_i && (idex_write_reg_i == ifid_rt_i)));

  assign active    = (state != HALT);
  assign flush_evt = active && redirect_i;
  // A redirect squashes the dependent instruction, so it wins over the stall.
  assign stall_evt = active && !redirect_i && hz;

  always_comb begin
    pc_enable_o   = 1'b0;
    ifid_enable_o = 1'b0;
    ifid_flush_o  = 1'b0;
    idex_enable_o = 1'b0;
    idex_flush_o  = 1'b0;
    if (active) begin
      idex_enable_o = 1'b1;
      if (redirect_i) begin
        pc_enable_o   = 1'b1;
        ifid_enable_o = 1'b1;
        ifid_flush_o  = 1'b1;
        idex_flush_o  = 1'b1;
      end else if (hz) begin
        // Hold PC and IF/ID, inject one bubble; the bubble clears hz next cycle.
        idex_flush_o  = 1'b1;
      end else begin
        pc_enable_o   = 1'b1;
        ifid_enable_o = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= RUN;
      halted_o      <= 1'b0;
      stall_count_o <= '0;
      flush_count_o <= '0;
    end else begin
      if (stall_evt && (stall_count_o != CNT_MAX)) stall_count_o <= stall_count_o + 1'b1;
      if (flush_evt && (flush_count_o != CNT_MAX)) flush_count_o <= flush_count_o + 1'b1;
      case (state)
        RUN: begin
          if (halt_req_i) begin
            state    <= HALT;
            halted_o <= 1'b1;
          end
        end
        HALT: begin
          // Dropping the halt request takes priority over a step pulse.
          if (!halt_req_i) begin
            state    <= RUN;
            halted_o <= 1'b0;
          end else if (step_i) begin
            state    <= STEP;
            halted_o <= 1'b0;
          end
        end
        STEP: begin
          if (halt_req_i) begin
            state    <= HALT;
            halted_o <= 1'b1;
          end else begin
            state    <= RUN;
            halted_o <= 1'b0;
          end
        end
        default: begin
          state    <= RUN;
          halted_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctl.sv
// tb/tb_pipeline_hazard_ctl.sv - self-checking bench for pipeline_hazard_ctl
//
// Purpose:
//   Table-driven output vectors, hand-written multi-cycle sequences and a
//   randomized run compared against a behavioural model of the controller.
//
// Ports: none (top-level bench).

module tb_pipeline_hazard_ctl;

  localparam int CW   = 16;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [4:0]    ifid_rs_i, ifid_rt_i, idex_write_reg_i;
  logic          ifid_uses_rt_i, idex_reg_write_i, redirect_i, halt_req_i, step_i;
  logic          pc_enable_o, ifid_enable_o, ifid_flush_o, idex_enable_o, idex_flush_o;
  logic          halted_o;
  logic [CW-1:0] stall_count_o, flush_count_o;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: mode of the debug unit plus two plain integer counters.
  bit m_halted   = 1'b0;
  bit m_stepping = 1'b0;
  int m_stall    = 0;
  int m_flush    = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctl #(.CNT_WIDTH(CW)) dut (
    .clk              (clk),
    .reset            (reset),
    .ifid_rs_i        (ifid_rs_i),
    .ifid_rt_i        (ifid_rt_i),
    .ifid_uses_rt_i   (ifid_uses_rt_i),
    .idex_reg_write_i (idex_reg_write_i),
    .idex_write_reg_i (idex_write_reg_i),
    .redirect_i       (redirect_i),
    .halt_req_i       (halt_req_i),
    .step_i           (step_i),
    .pc_enable_o      (pc_enable_o),
    .ifid_enable_o    (ifid_enable_o),
    .ifid_flush_o     (ifid_flush_o),
    .idex_enable_o    (idex_enable_o),
    .idex_flush_o     (idex_flush_o),
    .halted_o         (halted_o),
    .stall_count_o    (stall_count_o),
    .flush_count_o    (flush_count_o)
  );

  typedef struct {
    logic [4:0] rs, rt, wr;
    logic       ur, rw, rd;
    logic [4:0] exp;  // {pc_en, ifid_en, ifid_fl, idex_en, idex_fl}
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic bit model_hz();
    return idex_reg_write_i && (idex_write_reg_i != 0) &&
           ((idex_write_reg_i == ifid_rs_i) || (ifid_uses_rt_i && (idex_write_reg_i == ifid_rt_i)));
  endfunction

  function automatic logic [4:0] model_ctl();
    if (m_halted)   return 5'b00000;
    if (redirect_i) return 5'b11111;
    if (model_hz()) return 5'b00011;
    return 5'b11010;
  endfunction

  task automatic compare_model();
    check("ctl", {pc_enable_o, ifid_enable_o, ifid_flush_o, idex_enable_o, idex_flush_o}, model_ctl());
    check("halted", halted_o, m_halted);
    check("stall_cnt", stall_count_o, m_stall);
    check("flush_cnt", flush_count_o, m_flush);
  endtask

  task automatic model_update();
    if (reset) begin
      m_halted = 0; m_stepping = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (!m_halted) begin
        if (redirect_i)      m_flush = (m_flush < CMAX) ? m_flush + 1 : CMAX;
        else if (model_hz()) m_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
      end
      if (m_stepping) begin
        m_stepping = 0;
        m_halted   = halt_req_i;
      end else if (m_halted) begin
        if (!halt_req_i) m_halted = 0;
        else if (step_i) begin m_halted = 0; m_stepping = 1; end
      end else begin
        m_halted = halt_req_i;
      end
    end
  endtask

  // Inputs are driven just after a rising edge; outputs are sampled mid-cycle.
  task automatic tick(input bit chk);
    #3;
    if (chk) compare_model();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    ifid_rs_i = 0; ifid_rt_i = 0; ifid_uses_rt_i = 0;
    idex_reg_write_i = 0; idex_write_reg_i = 0;
    redirect_i = 0; halt_req_i = 0; step_i = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    tick(0);
    reset = 0;
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{rs:5'd8, rt:5'd0, wr:5'd8, ur:0, rw:1, rd:0, exp:5'b00011}; // rs hazard
    vecs[1] = '{rs:5'd0, rt:5'd0, wr:5'd0, ur:1, rw:1, rd:0, exp:5'b11010}; // $0 never hazards
    vecs[2] = '{rs:5'd1, rt:5'd9, wr:5'd9, ur:0, rw:1, rd:0, exp:5'b11010}; // rt not read
    vecs[3] = '{rs:5'd1, rt:5'd9, wr:5'd9, ur:1, rw:1, rd:0, exp:5'b00011}; // rt hazard
    vecs[4] = '{rs:5'd8, rt:5'd8, wr:5'd8, ur:1, rw:0, rd:0, exp:5'b11010}; // no reg_write
    vecs[5] = '{rs:5'd8, rt:5'd0, wr:5'd8, ur:0, rw:1, rd:1, exp:5'b11111}; // redirect beats hz
    vecs[6] = '{rs:5'd3, rt:5'd4, wr:5'd5, ur:1, rw:1, rd:1, exp:5'b11111}; // plain redirect
    vecs[7] = '{rs:5'd31, rt:5'd2, wr:5'd31, ur:0, rw:1, rd:0, exp:5'b00011}; // top register

    reset = 1;
    idle_inputs();
    @(posedge clk); #1;
    do_reset();

    // Reset state
    #3;
    check("rst_halted", halted_o, 0);
    check("rst_stall", stall_count_o, 0);
    check("rst_flush", flush_count_o, 0);
    check("rst_ctl", {pc_enable_o, ifid_enable_o, ifid_flush_o, idex_enable_o, idex_flush_o}, 5'b11010);
    @(posedge clk); model_update(); #1;

    // Table-driven combinational vectors in RUN
    foreach (vecs[i]) begin
      ifid_rs_i = vecs[i].rs; ifid_rt_i = vecs[i].rt; ifid_uses_rt_i = vecs[i].ur;
      idex_reg_write_i = vecs[i].rw; idex_write_reg_i = vecs[i].wr; redirect_i = vecs[i].rd;
      #3;
      check($sformatf("vec%0d", i),
            {pc_enable_o, ifid_enable_o, ifid_flush_o, idex_enable_o, idex_flush_o}, vecs[i].exp);
      @(posedge clk); model_update(); #1;
    end

    // Load-use stall lasts one cycle, then the bubble clears the hazard
    do_reset();
    idex_reg_write_i = 1; idex_write_reg_i = 8; ifid_rs_i = 8;
    #3;
    check("stall_pc_en", pc_enable_o, 0);
    check("stall_idex_fl", idex_flush_o, 1);
    @(posedge clk); model_update(); #1;
    idex_reg_write_i = 0; idex_write_reg_i = 0;
    #3;
    check("stall_cnt_1", stall_count_o, 1);
    check("after_stall_ctl", {pc_enable_o, ifid_enable_o, idex_enable_o}, 3'b111);
    @(posedge clk); model_update(); #1;

    // Redirect with a simultaneous hazard counts as a flush only
    do_reset();
    idex_reg_write_i = 1; idex_write_reg_i = 8; ifid_rs_i = 8; redirect_i = 1;
    tick(1);
    idle_inputs();
    #3;
    check("redir_flush_cnt", flush_count_o, 1);
    check("redir_stall_cnt", stall_count_o, 0);
    @(posedge clk); model_update(); #1;

    // Halt, single step, resume
    do_reset();
    halt_req_i = 1;
    #3; check("halt_req_cycle_pc", pc_enable_o, 1);
    @(posedge clk); model_update(); #1;
    #3;
    check("halted_set", halted_o, 1);
    check("halted_ctl", {pc_enable_o, ifid_enable_o, idex_enable_o}, 3'b000);
    @(posedge clk); model_update(); #1;
    redirect_i = 1;  // held while halted, acted on during the step
    step_i = 1;
    tick(1);
    step_i = 0;
    #3;
    check("step_active", halted_o, 0);
    check("step_ctl", {pc_enable_o, ifid_flush_o, idex_flush_o}, 3'b111);
    @(posedge clk); model_update(); #1;
    redirect_i = 0;
    #3;
    check("step_rehalt", halted_o, 1);
    check("step_flush_cnt", flush_count_o, 1);
    @(posedge clk); model_update(); #1;
    halt_req_i = 0; step_i = 1;  // release wins over step
    tick(1);
    step_i = 0;
    #3; check("resume_run", halted_o, 0);
    @(posedge clk); model_update(); #1;

    // Reset while halted with nonzero counters
    redirect_i = 1; tick(1); redirect_i = 0;
    idex_reg_write_i = 1; idex_write_reg_i = 4; ifid_rs_i = 4; tick(1);
    idle_inputs(); halt_req_i = 1; tick(1); tick(1);
    #3; check("pre_rst_halted", halted_o, 1);
    reset = 1;
    @(posedge clk); model_update(); #1;
    reset = 0; halt_req_i = 0;
    #3;
    check("rst_halt_halted", halted_o, 0);
    check("rst_halt_stall", stall_count_o, 0);
    check("rst_halt_flush", flush_count_o, 0);
    check("rst_halt_ctl", pc_enable_o, 1);
    @(posedge clk); model_update(); #1;

    // Randomized run against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      reset            = ($urandom_range(0, 99) == 0);
      ifid_rs_i        = 5'($urandom_range(0, 3));
      ifid_rt_i        = 5'($urandom_range(0, 3));
      ifid_uses_rt_i   = 1'($urandom);
      idex_reg_write_i = 1'($urandom);
      idex_write_reg_i = 5'($urandom_range(0, 3));
      redirect_i       = ($urandom_range(0, 3) == 0);
      halt_req_i       = ($urandom_range(0, 3) == 0) ? ~halt_req_i : halt_req_i;
      step_i           = ($urandom_range(0, 2) == 0);
      tick(1);
    end

    // Stall counter saturation
    do_reset();
    idex_reg_write_i = 1; idex_write_reg_i = 7; ifid_rs_i = 7;
    for (int c = 0; c < CMAX; c++) begin
      @(posedge clk); model_update(); #1;
    end
    #3; check("sat_reach", stall_count_o, 16'hFFFF);
    @(posedge clk); model_update(); #1;
    @(posedge clk); model_update(); #1;
    #3;
    check("sat_hold", stall_count_o, 16'hFFFF);
    check("sat_flush", flush_count_o, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
